// File: rtl/asu_arbiter_pkg.sv
// Shared definitions for the add/subtract unit arbiter: op encoding, FSM states
// and the signed-overflow rule used when a result is captured.
package asu_arbiter_pkg;

   localparam int   ASU_DEFAULT_WIDTH = 16;
   localparam logic ASU_OP_ADD        = 1'b0;
   localparam logic ASU_OP_SUB        = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } asu_state_e;

   // Overflow is judged from the original operands, so B = most-negative on a
   // subtract still follows the ordinary sign rule.
   function automatic logic asu_ovf(input logic op, input logic aMsb,
                                    input logic bMsb, input logic rMsb);
      if (op == ASU_OP_SUB) begin
         return (aMsb != bMsb) && (rMsb != aMsb);
      end
      return (aMsb == bMsb) && (rMsb != aMsb);
   endfunction

endpackage

// File: rtl/asu_arbiter_if.sv
// Request/response bundle between NREQ requesters (master) and the arbiter (slave).
interface asu_arbiter_if
   import asu_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = ASU_DEFAULT_WIDTH,
   parameter int IDW   = 2
);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_op;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_ready;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [WIDTH-1:0]      resp_data;
   logic [IDW-1:0]        resp_id;
   logic                  resp_ovf;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_id, resp_ovf
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_data, resp_id, resp_ovf
   );

endinterface

// File: rtl/asu.sv
// Add/subtract unit: ripple adder pair with op select. Subtract is A + ~B + 1.
module asu #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             arithADD,
   input  logic             arithSUB,
   output logic [WIDTH-1:0] outASU
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;

   assign sum    = inA + inB;
   assign diff   = inA + ~inB + WIDTH'(1);
   assign outASU = arithSUB ? diff : (arithADD ? sum : '0);

endmodule

// File: rtl/asu_arbiter_rr_pick.sv
// Round-robin priority select: first valid requester strictly after ptr, with wrap.
module asu_arbiter_rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   // The last winner is scanned last (k = NREQ), so it ranks lowest next time.
   always_comb begin
      int              cand;
      logic [IDW-1:0]  candIdx;
      cand    = 0;
      candIdx = '0;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         cand    = (int'(ptr_i) + k) % NREQ;
         candIdx = IDW'(cand);
         if (!any_o && valid_i[candIdx]) begin
            any_o            = 1'b1;
            idx_o            = candIdx;
            grant_o[candIdx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/asu_arbiter.sv
// Shares one ASU among NREQ requesters: round-robin grant, registered operands,
// registered result returned with requester ID over a valid/ready channel.
module asu_arbiter
   import asu_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = ASU_DEFAULT_WIDTH,
   parameter int IDW   = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   asu_arbiter_if.slave bus,
   output logic         busy_o
);

   asu_state_e       state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             op_q;
   logic [IDW-1:0]   ptr_q;
   logic             resp_valid_q;
   logic [WIDTH-1:0] resp_data_q;
   logic [IDW-1:0]   resp_id_q;
   logic             resp_ovf_q;

   logic [NREQ-1:0]  pickGrant;
   logic [IDW-1:0]   pickIdx;
   logic             pickAny;
   logic             canGrant;
   logic             accept;
   logic [WIDTH-1:0] selA;
   logic [WIDTH-1:0] selB;
   logic             selOp;
   logic [WIDTH-1:0] asuOut;
   logic             execOvf;

   asu_arbiter_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .valid_i (bus.req_valid),
      .ptr_i   (ptr_q),
      .grant_o (pickGrant),
      .idx_o   (pickIdx),
      .any_o   (pickAny)
   );

   asu #(
      .WIDTH (WIDTH)
   ) u_asu (
      .inA      (a_q),
      .inB      (b_q),
      .arithADD (op_q == ASU_OP_ADD),
      .arithSUB (op_q == ASU_OP_SUB),
      .outASU   (asuOut)
   );

   // A new request may be taken in IDLE, or in DONE in the same cycle the
   // pending result is consumed, giving back-to-back operation every 2 cycles.
   assign canGrant      = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.resp_ready);
   assign accept        = canGrant && pickAny;
   assign bus.req_ready = canGrant ? pickGrant : '0;

   assign selA    = bus.req_a[int'(pickIdx) * WIDTH +: WIDTH];
   assign selB    = bus.req_b[int'(pickIdx) * WIDTH +: WIDTH];
   assign selOp   = bus.req_op[pickIdx];
   assign execOvf = asu_ovf(op_q, a_q[WIDTH-1], b_q[WIDTH-1], asuOut[WIDTH-1]);

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_ovf   = resp_ovf_q;
   assign busy_o         = (state_q != ST_IDLE);

   // The pointer doubles as the in-flight requester ID: it only moves on a grant.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= ASU_OP_ADD;
         ptr_q        <= IDW'(NREQ - 1);
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_id_q    <= '0;
         resp_ovf_q   <= 1'b0;
      end else begin
         if (accept) begin
            a_q   <= selA;
            b_q   <= selB;
            op_q  <= selOp;
            ptr_q <= pickIdx;
         end
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               resp_data_q  <= asuOut;
               resp_id_q    <= ptr_q;
               resp_ovf_q   <= execOvf;
               resp_valid_q <= 1'b1;
               state_q      <= ST_DONE;
            end
            ST_DONE: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= accept ? ST_EXEC : ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_asu_arbiter.sv
// Self-checking bench for asu_arbiter: table-driven single requests plus
// round-robin, backpressure and asynchronous-reset sequences, with a response scoreboard.
module tb_asu_arbiter;
   import asu_arbiter_pkg::*;

   localparam int NREQ  = 4;
   localparam int WIDTH = 16;
   localparam int IDW   = 2;

   typedef struct {
      int          req;
      logic        op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] expData;
      logic        expOvf;
   } vec_t;

   typedef struct {
      logic [15:0] data;
      int          id;
      logic        ovf;
      int          cycle;
   } resp_t;

   logic  clk   = 1'b0;
   logic  rst_n = 1'b0;
   logic  busy;
   int    cycle     = 0;
   int    testCount = 0;
   int    failCount = 0;
   resp_t sbQueue[$];
   vec_t  vecs[10];

   asu_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

   asu_arbiter #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH),
      .IDW   (IDW)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cycle);
      end
   endtask

   // Reference arithmetic done in wide signed integers, independent of bit tricks.
   task automatic modelResult(input logic op, input logic [15:0] a, input logic [15:0] b,
                              output logic [15:0] d, output logic o);
      int sa;
      int sb;
      int r;
      sa = int'($signed(a));
      sb = int'($signed(b));
      r  = op ? (sa - sb) : (sa + sb);
      d  = r[15:0];
      o  = (r > 32767) || (r < -32768);
   endtask

   task automatic pushExpected(input logic [15:0] d, input int id, input logic o, input int cyc);
      resp_t e;
      e.data  = d;
      e.id    = id;
      e.ovf   = o;
      e.cycle = cyc;
      sbQueue.push_back(e);
   endtask

   task automatic driveReq(input int req, input logic op, input logic [15:0] a, input logic [15:0] b);
      bus.req_op[req]           = op;
      bus.req_a[req*16 +: 16]   = a;
      bus.req_b[req*16 +: 16]   = b;
      bus.req_valid[req]        = 1'b1;
   endtask

   task automatic waitGrant(input int req, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.req_ready[req]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         testCount++;
         failCount++;
         $display("[TB] FAIL grantTimeout: requester %0d got no grant, expected one within 20 cycles", req);
      end
   endtask

   task automatic waitAnyGrant(output int g, output bit ok);
      ok = 1'b0;
      g  = -1;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ready[i]) begin
               g  = i;
               ok = 1'b1;
            end
         end
      end
      if (!ok) begin
         testCount++;
         failCount++;
         $display("[TB] FAIL anyGrantTimeout: got no grant, expected one within 20 cycles");
      end
   endtask

   task automatic drainScoreboard();
      for (int n = 0; n < 30 && sbQueue.size() != 0; n++) begin
         @(negedge clk);
      end
      if (sbQueue.size() != 0) begin
         testCount++;
         failCount++;
         $display("[TB] FAIL drainTimeout: %0d responses outstanding, expected 0", sbQueue.size());
         sbQueue.delete();
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bit ok;
      @(posedge clk);
      #1;
      driveReq(v.req, v.op, v.a, v.b);
      waitGrant(v.req, ok);
      if (ok) begin
         checkOutput("grantVec", 32'(bus.req_ready), 32'(1) << v.req);
         pushExpected(v.expData, v.req, v.expOvf, cycle + 2);
      end
      @(posedge clk);
      #1;
      bus.req_valid[v.req] = 1'b0;
      drainScoreboard();
   endtask

   // Response monitor: compares each consumed result with the scoreboard head.
   initial begin
      resp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            checkOutput("readyOneHot", 32'($countones(bus.req_ready) <= 1), 32'(1));
            if (bus.resp_valid && !bus.resp_ready) begin
               checkOutput("stallReady", 32'(bus.req_ready), 32'(0));
            end
            if (bus.resp_valid && bus.resp_ready) begin
               if (sbQueue.size() == 0) begin
                  testCount++;
                  failCount++;
                  $display("[TB] FAIL unexpectedResp: got id %0d data 0x%0h, expected no response",
                           bus.resp_id, bus.resp_data);
               end else begin
                  e = sbQueue.pop_front();
                  checkOutput("respData", 32'(bus.resp_data), 32'(e.data));
                  checkOutput("respId", 32'(bus.resp_id), 32'(e.id));
                  checkOutput("respOvf", 32'(bus.resp_ovf), 32'(e.ovf));
                  if (e.cycle >= 0) begin
                     checkOutput("respLatency", 32'(cycle), 32'(e.cycle));
                  end
               end
            end
         end
      end
   end

   initial begin
      bit          ok;
      int          g;
      int          prevGrant;
      logic [15:0] rrA[NREQ];
      logic [15:0] rrB[NREQ];
      logic        rrOp[NREQ];
      logic [15:0] d;
      logic        o;

      bus.req_valid  = '0;
      bus.req_op     = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = 1'b1;

      vecs[0] = '{0, ASU_OP_ADD, 16'd5,    16'd9,    16'd14,   1'b0};
      vecs[1] = '{2, ASU_OP_SUB, 16'd7,    16'd10,   16'hFFFD, 1'b0};
      vecs[2] = '{2, ASU_OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1};
      vecs[3] = '{1, ASU_OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1};
      vecs[4] = '{3, ASU_OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};
      vecs[5] = '{1, ASU_OP_SUB, 16'h0000, 16'h8000, 16'h8000, 1'b1};
      vecs[6] = '{0, ASU_OP_SUB, 16'h8000, 16'h8000, 16'h0000, 1'b0};
      vecs[7] = '{3, ASU_OP_ADD, 16'h8000, 16'hFFFF, 16'h7FFF, 1'b1};
      vecs[8] = '{2, ASU_OP_ADD, 16'h1234, 16'h4321, 16'h5555, 1'b0};
      vecs[9] = '{0, ASU_OP_SUB, 16'h0005, 16'h0003, 16'h0002, 1'b0};

      #12;
      checkOutput("rstRespValid", 32'(bus.resp_valid), 32'(0));
      checkOutput("rstRespData", 32'(bus.resp_data), 32'(0));
      checkOutput("rstRespId", 32'(bus.resp_id), 32'(0));
      checkOutput("rstRespOvf", 32'(bus.resp_ovf), 32'(0));
      checkOutput("rstReqReady", 32'(bus.req_ready), 32'(0));
      checkOutput("rstBusy", 32'(busy), 32'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
      end

      // Round-robin: fresh reset so requester 0 wins first, all four kept valid.
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         rrA[i]  = 16'(16'h1000 * (i + 1));
         rrB[i]  = 16'(i + 3);
         rrOp[i] = (i % 2 == 1);
         driveReq(i, rrOp[i], rrA[i], rrB[i]);
      end
      prevGrant = -1;
      for (int k = 0; k < 5; k++) begin
         waitAnyGrant(g, ok);
         if (!ok) break;
         checkOutput("rrOrder", 32'(g), 32'(k % NREQ));
         if (prevGrant >= 0) begin
            checkOutput("rrSpacing", 32'(cycle - prevGrant), 32'(2));
         end
         prevGrant = cycle;
         modelResult(rrOp[g], rrA[g], rrB[g], d, o);
         pushExpected(d, g, o, cycle + 2);
         @(posedge clk);
         #1;
         rrA[g] = rrA[g] + 16'h0321;
         driveReq(g, rrOp[g], rrA[g], rrB[g]);
      end
      bus.req_valid = '0;
      drainScoreboard();

      // Backpressure: result held for 5 cycles while requester 1 waits.
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
      driveReq(0, ASU_OP_ADD, 16'd100, 16'd23);
      waitGrant(0, ok);
      @(posedge clk);
      #1;
      bus.req_valid[0] = 1'b0;
      pushExpected(16'd123, 0, 1'b0, -1);
      driveReq(1, ASU_OP_ADD, 16'd1, 16'd2);
      @(negedge clk);
      checkOutput("bpExecReady", 32'(bus.req_ready), 32'(0));
      repeat (5) begin
         @(negedge clk);
         checkOutput("bpRespValid", 32'(bus.resp_valid), 32'(1));
         checkOutput("bpRespData", 32'(bus.resp_data), 32'(123));
         checkOutput("bpRespId", 32'(bus.resp_id), 32'(0));
         checkOutput("bpReqReady", 32'(bus.req_ready), 32'(0));
      end
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bpGrantOnReady", 32'(bus.req_ready), 32'(2));
      pushExpected(16'd3, 1, 1'b0, cycle + 2);
      @(posedge clk);
      #1;
      bus.req_valid[1] = 1'b0;
      drainScoreboard();

      // Asynchronous reset during EXEC: outputs clear without a clock edge.
      @(posedge clk);
      #1;
      driveReq(2, ASU_OP_SUB, 16'd50, 16'd8);
      waitGrant(2, ok);
      @(posedge clk);
      #1;
      bus.req_valid[2] = 1'b0;
      checkOutput("arBusyExec", 32'(busy), 32'(1));
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arRespValid", 32'(bus.resp_valid), 32'(0));
      checkOutput("arBusy", 32'(busy), 32'(0));
      checkOutput("arRespData", 32'(bus.resp_data), 32'(0));
      checkOutput("arRespId", 32'(bus.resp_id), 32'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      driveReq(0, ASU_OP_ADD, 16'd11, 16'd22);
      driveReq(3, ASU_OP_SUB, 16'd40, 16'd2);
      waitGrant(0, ok);
      if (ok) begin
         checkOutput("arFirstGrant", 32'(bus.req_ready), 32'(1));
         pushExpected(16'd33, 0, 1'b0, cycle + 2);
      end
      @(posedge clk);
      #1;
      bus.req_valid[0] = 1'b0;
      waitGrant(3, ok);
      if (ok) begin
         pushExpected(16'd38, 3, 1'b0, cycle + 2);
      end
      @(posedge clk);
      #1;
      bus.req_valid[3] = 1'b0;
      drainScoreboard();

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/asu_arbiter.md
Name: asu_arbiter

Overview:
- Shares one add/subtract unit (16-bit ripple adder pair with op select) among NREQ requesters, e.g. the SAYAC execute stage, address-generation logic and the loop-counter logic.
- Round-robin grant, registered operands, registered result returned with requester ID over a valid/ready response channel.
- Sits between the requester ports and a single ASU instance inside the datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, operand/result width; must match the ASU.
- IDW, 2, requester ID width, equal to clog2(NREQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request strobe.
- req_op  in  NREQ  per-requester op: 0=add, 1=sub.
- req_a  in  NREQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand B, same packing.
- req_ready  out  NREQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  WIDTH  A+B or A-B, modulo 2^WIDTH.
- resp_id  out  IDW  index of the requester that issued this result.
- resp_ovf  out  1  signed overflow of the operation.
- busy  out  1  high in EXEC or DONE.

Behaviour:
- Reset (rst=0, asynchronous) puts the FSM in IDLE. Also clears: resp_valid=0, resp_data=0, resp_id=0, resp_ovf=0, req_ready=0, busy=0, operand regs=0, RR pointer=NREQ-1 (so requester 0 has first priority).
- Reset mid-operation discards the in-flight request; no response is ever produced for it.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - req_ready is combinational: one-hot for the first i with req_valid[i]=1, searching from ptr+1 upward with wrap-around.
  - If any request: latch a, b, op, id; ptr<=id; go to EXEC. Otherwise stay in IDLE.
- EXEC:
  - req_ready=0.
  - Drive the ASU from the operand regs: arithADD=~op, arithSUB=op.
  - Capture outASU into resp_data, plus id and overflow; resp_valid<=1; go to DONE.
- DONE:
  - resp_valid=1, outputs held stable until resp_ready.
  - If resp_ready=0: stay in DONE, req_ready=0.
  - If resp_ready=1 and a request is pending: grant (req_ready as in IDLE) in the same cycle, latch operands, go to EXEC. resp_valid drops to 0 next cycle.
  - If resp_ready=1 and no request is pending: go to IDLE, resp_valid<=0.
- Latency: accept at cycle t gives resp_valid at t+2.
- Throughput: best case one result per 2 cycles.
- Arithmetic:
  - Sub is A + (-B) mod 2^WIDTH.
  - resp_ovf for add = (a[msb]==b[msb]) & (sum[msb]!=a[msb]).
  - resp_ovf for sub = (a[msb]!=b[msb]) & (diff[msb]!=a[msb]).
  - B=0x8000 on sub: -B=0x8000; ovf is still computed from the original operands as above.
- Fairness: the pointer advances only on a grant. A requester that keeps req_valid high waits at most NREQ-1 grants.
- Requester rules: it must hold req_valid, op, a and b stable until accepted. The block does not require stability of non-granted requesters.
- Invariants: req_ready has at most one bit set, and is never set while in EXEC.

Decomposition:
- Shared package holds:
  - op encoding constants ASU_OP_ADD=0, ASU_OP_SUB=1;
  - FSM state encodings ST_IDLE, ST_EXEC, ST_DONE;
  - default WIDTH=16.
- One natural sub-module: rr_pick (NREQ-bit round-robin priority select; inputs valid vector and ptr; outputs one-hot grant and index).
- The ASU is instantiated unmodified as the compute element.

Test Plan:
- Single add: req0 a=5, b=9, op=add, resp_ready=1. Expect grant at t, resp_valid at t+2, resp_data=14, resp_id=0, ovf=0.
- Sub with wrap: req2 a=7, b=10, op=sub. Expect resp_data=0xFFFD, id=2, ovf=0. Then a=0x8000, b=1, sub: expect 0x7FFF, ovf=1.
- Round-robin: all 4 requesters valid continuously with distinct operands. Expect grant order 0,1,2,3,0; one result every 2 cycles; each result's id and data match its requester.
- Backpressure: resp_ready=0 for 5 cycles with req1 pending. Expect resp_data/id stable, req_ready=0 throughout; req1 is granted in the cycle resp_ready rises.
- Async reset mid-op: assert rst=0 during EXEC. Expect immediate resp_valid=0 and busy=0 without waiting for a clock edge; after release, req0 is granted before req3 when both are valid.
- Add overflow: a=0x7FFF, b=1, add. Expect resp_data=0x8000, ovf=1. Then a=0xFFFF, b=1, add: expect 0x0000, ovf=0.
